// File: rtl/fixed_divider_if.sv
// Start/busy/done handshake bundle for the fixed_divider block.
// The requester uses the master modport; the divider uses the slave modport.
interface fixed_divider_if;
  logic        i_start;
  logic [15:0] i_num;
  logic [15:0] i_den;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_quot;
  logic        o_sat;

  modport master (
    output i_start, i_num, i_den,
    input  o_busy, o_done, o_quot, o_sat
  );

  modport slave (
    input  i_start, i_num, i_den,
    output o_busy, o_done, o_quot, o_sat
  );
endinterface

// File: rtl/fixed_divider.sv
// fixed_divider: iterative signed Q6.10 restoring divider, one quotient bit
// per clock, fixed 27-cycle latency from accepted start to o_done.
// Optional feature macro: FIXED_DIVIDER_SAT_EN (symmetric saturation and
// o_sat flag). Without it overflow wraps and o_sat is tied low; the
// divide-by-zero override applies in both builds.
module fixed_divider #(
  parameter int FRAC = 10
) (
  input  logic            clk,
  input  logic            reset,
  fixed_divider_if.slave  bus
);

  localparam int ITERS = 16 + FRAC;
  localparam int CW    = $clog2(ITERS);
`ifdef FIXED_DIVIDER_SAT_EN
  // Full quotient magnitude is kept so overflow above bit 14 can be seen.
  localparam int QW    = ITERS;
`else
  // Only the low 16 quotient bits reach the output when overflow wraps.
  localparam int QW    = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX
  } state_t;

  state_t            r_state;
  logic              r_sign;
  logic              r_num_neg;
  logic              r_dz;
  logic [15:0]       r_den_abs;
  logic [ITERS-1:0]  r_dividend;
  logic [15:0]       r_rem;
  logic [QW-1:0]     r_quo;
  logic [CW-1:0]     r_count;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_quot;
`ifdef FIXED_DIVIDER_SAT_EN
  logic              r_sat;
`endif

  // Magnitudes as 16-bit unsigned: 0x8000 negates to itself, read as +32768.
  logic [15:0] w_num_abs;
  logic [15:0] w_den_abs;
  logic [16:0] w_rem_sh;
  logic        w_ge;
  logic [15:0] w_rem_next;
  logic [15:0] w_quot_fix;
  logic        w_sat_fix;

  assign w_num_abs = bus.i_num[15] ? (16'd0 - bus.i_num) : bus.i_num;
  assign w_den_abs = bus.i_den[15] ? (16'd0 - bus.i_den) : bus.i_den;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    w_rem_sh   = {r_rem, r_dividend[ITERS-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_den_abs});
    w_rem_next = w_ge ? 16'(w_rem_sh - {1'b0, r_den_abs}) : w_rem_sh[15:0];
  end

  // Final result: signed wrap/saturate plus the divide-by-zero override.
  always_comb begin
    w_quot_fix = r_sign ? (16'd0 - r_quo[15:0]) : r_quo[15:0];
    w_sat_fix  = 1'b0;
`ifdef FIXED_DIVIDER_SAT_EN
    if (r_quo[QW-1:15] != '0) begin
      w_sat_fix  = 1'b1;
      w_quot_fix = r_sign ? 16'h8001 : 16'h7FFF;
    end
`endif
    if (r_dz) begin
`ifdef FIXED_DIVIDER_SAT_EN
      w_sat_fix  = 1'b1;
`endif
      w_quot_fix = r_num_neg ? 16'h8001 : 16'h7FFF;
    end
  end

  // Control FSM and datapath registers: IDLE -> DIV (ITERS steps) -> FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sign     <= 1'b0;
      r_num_neg  <= 1'b0;
      r_dz       <= 1'b0;
      r_den_abs  <= '0;
      r_dividend <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
`ifdef FIXED_DIVIDER_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_sign     <= bus.i_num[15] ^ bus.i_den[15];
            r_num_neg  <= bus.i_num[15];
            r_dz       <= (bus.i_den == '0);
            r_den_abs  <= w_den_abs;
            r_dividend <= {w_num_abs, {FRAC{1'b0}}};
            r_rem      <= '0;
            r_quo      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem      <= w_rem_next;
          r_dividend <= {r_dividend[ITERS-2:0], 1'b0};
          r_quo      <= {r_quo[QW-2:0], w_ge};
          r_count    <= r_count + CW'(1);
          if (r_count == CW'(ITERS - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quot  <= w_quot_fix;
`ifdef FIXED_DIVIDER_SAT_EN
          r_sat   <= w_sat_fix;
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_quot = r_quot;
`ifdef FIXED_DIVIDER_SAT_EN
  assign bus.o_sat  = r_sat;
`else
  assign bus.o_sat  = 1'b0;
  // Saturation flag is not produced in this build.
  logic w_unused_sat;
  assign w_unused_sat = w_sat_fix;
`endif

endmodule
